// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage : piso_pkg

// File: rtl/piso_serializer_bit_counter.sv
// Bit-index counter with synchronous clear, enable and terminal-count flag.
// Wraps to zero after MAX.
module bit_counter #(
    parameter int MAX = 7,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] r_count;

    // Count register: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == MAX_C) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == MAX_C);

endmodule : bit_counter

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready intake and framing strobes.
// Words can be accepted in the last-bit cycle so frames run back-to-back.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              sout_first,
    output logic              sout_last
);

    localparam int             CW     = $clog2(DATA_W);
    localparam logic [CW-1:0] PENULT = CW'(DATA_W - 2);

    piso_state_t       r_state;
    piso_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [DATA_W-1:0] w_shifted;
    logic [CW-1:0]     w_count;
    logic              w_tc;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_xfer;
    logic              w_ready;
    logic              w_sout_nxt;
    logic              w_first_nxt;
    logic              w_last_nxt;
    logic              r_sout;
    logic              r_valid;
    logic              r_first;
    logic              r_last;

    bit_counter #(
        .MAX (DATA_W - 1),
        .W   (CW)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    assign w_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_tc);
    assign w_xfer  = din_valid && w_ready;

    // The word moves toward whichever end feeds the serial line.
    assign w_shifted = LSB_FIRST ? {1'b0, r_shreg[DATA_W-1:1]}
                                 : {r_shreg[DATA_W-2:0], 1'b0};

    // Next-state, shift-register and counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = din;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_tc) begin
                    w_cnt_clr = 1'b1;
                    if (w_xfer) begin
                        w_state_nxt = SHIFT;
                        w_shreg_nxt = din;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shreg_nxt = '0;
                    end
                end else begin
                    w_shreg_nxt = w_shifted;
                    w_cnt_en    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_shreg_nxt = '0;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // Output flops are loaded with what the next cycle will present, so a
    // clear means bit 0 follows and an enable from PENULT means the last bit.
    assign w_sout_nxt  = (w_state_nxt == SHIFT) &&
                         (LSB_FIRST ? w_shreg_nxt[0] : w_shreg_nxt[DATA_W-1]);
    assign w_first_nxt = (w_state_nxt == SHIFT) && w_cnt_clr;
    assign w_last_nxt  = (w_state_nxt == SHIFT) && w_cnt_en && (w_count == PENULT);

    // State, data and registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_sout  <= w_sout_nxt;
            r_valid <= (w_state_nxt == SHIFT);
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign din_ready  = w_ready;
    assign sout       = r_sout;
    assign sout_valid = r_valid;
    assign sout_first = r_first;
    assign sout_last  = r_last;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (8-bit LSB/MSB first, 2-bit MSB first)
// compared every cycle against a queue-of-beats reference model.
module tb_piso_serializer;

    typedef logic [2:0] beat_t;  // {bit, first, last}

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din8;
    logic       v8;
    logic [1:0] din2;
    logic       v2;

    logic rdy_l8, so_l8, sv_l8, sf_l8, sl_l8;
    logic rdy_m8, so_m8, sv_m8, sf_m8, sl_m8;
    logic rdy_m2, so_m2, sv_m2, sf_m2, sl_m2;

    beat_t q_l8[$];
    beat_t q_m8[$];
    beat_t q_m2[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    acc8;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb8 (
        .clk(clk), .reset(reset), .din(din8), .din_valid(v8), .din_ready(rdy_l8),
        .sout(so_l8), .sout_valid(sv_l8), .sout_first(sf_l8), .sout_last(sl_l8)
    );

    piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb8 (
        .clk(clk), .reset(reset), .din(din8), .din_valid(v8), .din_ready(rdy_m8),
        .sout(so_m8), .sout_valid(sv_m8), .sout_first(sf_m8), .sout_last(sl_m8)
    );

    piso_serializer #(.DATA_W(2), .LSB_FIRST(1'b0)) u_msb2 (
        .clk(clk), .reset(reset), .din(din2), .din_valid(v2), .din_ready(rdy_m2),
        .sout(so_m2), .sout_valid(sv_m2), .sout_first(sf_m2), .sout_last(sl_m2)
    );

    function automatic beat_t mk_beat(input logic [7:0] w, input int width,
                                      input bit lsb, input int k);
        int         idx;
        logic [7:0] wv;
        wv  = w;
        idx = lsb ? k : (width - 1 - k);
        return {wv[idx], (k == 0), (k == width - 1)};
    endfunction

    // Expected {ready, valid, sout, first, last} given the pending beat count.
    function automatic logic [4:0] exp_vec(input int size, input beat_t head);
        if (size == 0) return 5'b10000;
        return {(size <= 1), 1'b1, head};
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (rdy,vld,sout,first,last) t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        bit rdy8;
        bit rdy2;
        @(posedge clk);
        rdy8 = (q_l8.size() <= 1);
        rdy2 = (q_m2.size() <= 1);
        acc8 = 1'b0;
        if (reset) begin
            q_l8.delete();
            q_m8.delete();
            q_m2.delete();
        end else begin
            if (q_l8.size() > 0) void'(q_l8.pop_front());
            if (q_m8.size() > 0) void'(q_m8.pop_front());
            if (q_m2.size() > 0) void'(q_m2.pop_front());
            if (v8 && rdy8) begin
                acc8 = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    q_l8.push_back(mk_beat(din8, 8, 1'b1, k));
                    q_m8.push_back(mk_beat(din8, 8, 1'b0, k));
                end
            end
            if (v2 && rdy2) begin
                for (int k = 0; k < 2; k++) q_m2.push_back(mk_beat({6'd0, din2}, 2, 1'b0, k));
            end
        end
        @(negedge clk);
        chk("lsb8", {rdy_l8, sv_l8, so_l8, sf_l8, sl_l8},
            exp_vec(q_l8.size(), (q_l8.size() > 0) ? q_l8[0] : 3'b000));
        chk("msb8", {rdy_m8, sv_m8, so_m8, sf_m8, sl_m8},
            exp_vec(q_m8.size(), (q_m8.size() > 0) ? q_m8[0] : 3'b000));
        chk("msb2", {rdy_m2, sv_m2, so_m2, sf_m2, sl_m2},
            exp_vec(q_m2.size(), (q_m2.size() > 0) ? q_m2[0] : 3'b000));
        din2 = 2'($urandom);
        v2   = 1'($urandom_range(0, 1));
    endtask

    // Hold a word valid until the model says it was taken, bounded.
    task automatic send8(input logic [7:0] w);
        int n;
        n    = 0;
        din8 = w;
        v8   = 1'b1;
        do begin
            step();
            n++;
        end while (!acc8 && n < 40);
        chk("accept", {4'b0000, acc8}, 5'b00001);
        v8   = 1'b0;
        din8 = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        din8  = 8'h00;
        v8    = 1'b0;
        din2  = 2'b00;
        v2    = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (10) step();

        send8(8'h1B);
        repeat (10) step();

        send8(8'hF0);
        send8(8'h0F);
        repeat (10) step();

        send8(8'hFF);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        send8(8'h01);
        repeat (10) step();

        reset = 1'b1;
        v8    = 1'b1;
        din8  = 8'hA5;
        step();
        reset = 1'b0;
        v8    = 1'b0;
        repeat (3) step();

        repeat (400) begin
            din8  = 8'($urandom);
            v8    = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        v8    = 1'b0;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_piso_serializer
